uart_mmio_ctrl: RTL and testbench

Memory-mapped I/O controller between the core's MMIO decode and the UART and performance counters. It buffers transmit and receive bytes in two small FIFOs and runs the ready/valid handshakes with the UART. It owns the cycle and instruction counters. CPU reads return data one cycle after the request, matching the synchronous-memory load path.

---
 rtl/uart_mmio_ctrl.sv | 145 ++++++++++++++
 tb/tb_uart_mmio_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio_ctrl.sv
// uart_mmio_ctrl: MMIO bridge from core loads/stores to the UART
// TX/RX byte FIFOs and the cycle/instret counters.
module uart_mmio_ctrl #(
  parameter int AWIDTH     = 32,
  parameter int DWIDTH     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AWIDTH-1:0] addr_in,
  input  logic [DWIDTH-1:0] data_in,
  input  logic              we_in,
  input  logic              re_in,
  input  logic              inst_valid_in,
  output logic [DWIDTH-1:0] data_reg_out,
  output logic [7:0]        data_uart_tx_out,
  output logic              ctrl_uart_tx_valid_out,
  input  logic              ctrl_uart_tx_ready_in,
  input  logic [7:0]        data_uart_rx_in,
  input  logic              ctrl_uart_rx_valid_in,
  output logic              ctrl_uart_rx_ready_out
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [AWIDTH-1:0] A_STAT = AWIDTH'(32'h8000_0000);
  localparam logic [AWIDTH-1:0] A_RX   = AWIDTH'(32'h8000_0004);
  localparam logic [AWIDTH-1:0] A_TX   = AWIDTH'(32'h8000_0008);
  localparam logic [AWIDTH-1:0] A_CYC  = AWIDTH'(32'h8000_0010);
  localparam logic [AWIDTH-1:0] A_INST = AWIDTH'(32'h8000_0014);
  localparam logic [AWIDTH-1:0] A_CRST = AWIDTH'(32'h8000_0018);

  logic [7:0]        tx_mem_q [FIFO_DEPTH];
  logic [7:0]        tx_mem_d [FIFO_DEPTH];
  logic [7:0]        rx_mem_q [FIFO_DEPTH];
  logic [7:0]        rx_mem_d [FIFO_DEPTH];
  logic [PW-1:0]     tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [PW-1:0]     rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [CW-1:0]     tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic              tx_drop_q, tx_drop_d;
  logic [31:0]       cyc_q, cyc_d, inst_q, inst_d;
  logic [DWIDTH-1:0] data_reg_q, data_reg_d;
  logic [DWIDTH-1:0] rdata;

  logic sel_stat, sel_rx, sel_tx, sel_cyc, sel_inst, sel_crst;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, tx_pop, rx_push, rx_pop, drop_set, drop_clr;
  logic [3:0] status;
  logic unused_data;

  assign sel_stat = addr_in == A_STAT;
  assign sel_rx   = addr_in == A_RX;
  assign sel_tx   = addr_in == A_TX;
  assign sel_cyc  = addr_in == A_CYC;
  assign sel_inst = addr_in == A_INST;
  assign sel_crst = addr_in == A_CRST;

  assign tx_full  = tx_cnt_q == FULL_CNT;
  assign tx_empty = tx_cnt_q == '0;
  assign rx_full  = rx_cnt_q == FULL_CNT;
  assign rx_empty = rx_cnt_q == '0;

  // Push/pop qualifiers; fullness always judged on pre-edge counts.
  assign tx_push  = we_in && sel_tx && !tx_full;
  assign drop_set = we_in && sel_tx && tx_full;
  assign drop_clr = we_in && sel_stat && data_in[2];
  assign tx_pop   = !tx_empty && ctrl_uart_tx_ready_in;
  assign rx_push  = ctrl_uart_rx_valid_in && !rx_full;
  assign rx_pop   = re_in && sel_rx && !rx_empty;

  assign status = {tx_empty, tx_drop_q, !rx_empty, !tx_full};
  assign unused_data = ^data_in;

  assign ctrl_uart_tx_valid_out = !tx_empty;
  assign ctrl_uart_rx_ready_out = !rx_full;
  assign data_uart_tx_out       = tx_mem_q[tx_rp_q];
  assign data_reg_out           = data_reg_q;

  // Next-state for both FIFOs, sticky drop flag and counters.
  always_comb begin
    tx_mem_d = tx_mem_q;
    rx_mem_d = rx_mem_q;
    if (tx_push) tx_mem_d[tx_wp_q] = data_in[7:0];
    if (rx_push) rx_mem_d[rx_wp_q] = data_uart_rx_in;
    tx_wp_d  = tx_wp_q + PW'(tx_push);
    tx_rp_d  = tx_rp_q + PW'(tx_pop);
    rx_wp_d  = rx_wp_q + PW'(rx_push);
    rx_rp_d  = rx_rp_q + PW'(rx_pop);
    tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    tx_drop_d = drop_set ? 1'b1 : (drop_clr ? 1'b0 : tx_drop_q);
    cyc_d  = cyc_q + 32'd1;
    inst_d = inst_q + {31'd0, inst_valid_in};
    if (we_in && sel_crst) begin
      cyc_d  = '0;
      inst_d = '0;
    end
  end

  // Load data mux, captured on re_in and held otherwise.
  always_comb begin
    rdata = '0;
    unique case (1'b1)
      sel_stat: rdata = DWIDTH'(status);
      sel_rx:   rdata = rx_empty ? '0 : DWIDTH'(rx_mem_q[rx_rp_q]);
      sel_cyc:  rdata = DWIDTH'(cyc_q);
      sel_inst: rdata = DWIDTH'(inst_q);
      default:  rdata = '0;
    endcase
    data_reg_d = re_in ? rdata : data_reg_q;
  end

  // State registers; reset flushes FIFOs and clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        tx_mem_q[i] <= '0;
        rx_mem_q[i] <= '0;
      end
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      tx_drop_q  <= 1'b0;
      cyc_q      <= '0;
      inst_q     <= '0;
      data_reg_q <= '0;
    end else begin
      tx_mem_q   <= tx_mem_d;
      rx_mem_q   <= rx_mem_d;
      tx_wp_q    <= tx_wp_d;
      tx_rp_q    <= tx_rp_d;
      rx_wp_q    <= rx_wp_d;
      rx_rp_q    <= rx_rp_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_drop_q  <= tx_drop_d;
      cyc_q      <= cyc_d;
      inst_q     <= inst_d;
      data_reg_q <= data_reg_d;
    end
  end
endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// tb_uart_mmio_ctrl: directed self-checking bench
// for the UART MMIO controller.
module tb_uart_mmio_ctrl;
  localparam logic [31:0] A_STAT = 32'h8000_0000;
  localparam logic [31:0] A_RX   = 32'h8000_0004;
  localparam logic [31:0] A_TX   = 32'h8000_0008;
  localparam logic [31:0] A_CYC  = 32'h8000_0010;
  localparam logic [31:0] A_INST = 32'h8000_0014;
  localparam logic [31:0] A_CRST = 32'h8000_0018;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr_in, data_in;
  logic        we_in, re_in, inst_valid_in;
  logic [31:0] data_reg_out;
  logic [7:0]  data_uart_tx_out;
  logic        ctrl_uart_tx_valid_out, ctrl_uart_tx_ready_in;
  logic [7:0]  data_uart_rx_in;
  logic        ctrl_uart_rx_valid_in, ctrl_uart_rx_ready_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_mmio_ctrl dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .addr_in                (addr_in),
    .data_in                (data_in),
    .we_in                  (we_in),
    .re_in                  (re_in),
    .inst_valid_in          (inst_valid_in),
    .data_reg_out           (data_reg_out),
    .data_uart_tx_out       (data_uart_tx_out),
    .ctrl_uart_tx_valid_out (ctrl_uart_tx_valid_out),
    .ctrl_uart_tx_ready_in  (ctrl_uart_tx_ready_in),
    .data_uart_rx_in        (data_uart_rx_in),
    .ctrl_uart_rx_valid_in  (ctrl_uart_rx_valid_in),
    .ctrl_uart_rx_ready_out (ctrl_uart_rx_ready_out)
  );

  // All bus tasks start and end on a falling edge.
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr_in = a;
    data_in = d;
    we_in   = 1'b1;
    @(negedge clk);
    we_in   = 1'b0;
    addr_in = '0;
  endtask

  task automatic load(input logic [31:0] a, output logic [31:0] v);
    addr_in = a;
    re_in   = 1'b1;
    @(negedge clk);
    re_in   = 1'b0;
    addr_in = '0;
    v = data_reg_out;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    checks++;
    if (ctrl_uart_tx_valid_out !== 1'b0 || ctrl_uart_rx_ready_out !== 1'b1
        || data_reg_out !== 32'h0 || data_uart_tx_out !== 8'h0) begin
      errors++;
      $display("FAIL reset_outs: txv=%b rxr=%b dreg=%h dtx=%h want 0 1 0 0",
               ctrl_uart_tx_valid_out, ctrl_uart_rx_ready_out,
               data_reg_out, data_uart_tx_out);
    end
    load(A_STAT, v);
    checks++;
    if (v !== 32'h9) begin
      errors++;
      $display("FAIL reset_status: got %h want 00000009", v);
    end
  endtask

  task automatic test_tx;
    logic [31:0] v;
    ctrl_uart_tx_ready_in = 1'b0;
    for (int i = 0; i < 4; i++) store(A_TX, 32'hABCD_0041 + i);
    load(A_STAT, v);
    checks++;
    if (v !== 32'h0) begin
      errors++;
      $display("FAIL tx_full_status: got %h want 00000000", v);
    end
    store(A_TX, 32'h45);
    load(A_STAT, v);
    checks++;
    if (v !== 32'h4) begin
      errors++;
      $display("FAIL tx_drop_status: got %h want 00000004", v);
    end
    ctrl_uart_tx_ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ctrl_uart_tx_valid_out !== 1'b1 || data_uart_tx_out !== 8'(8'h41 + i)) begin
        errors++;
        $display("FAIL tx_emit%0d: valid=%b byte=%h want 1 %h", i,
                 ctrl_uart_tx_valid_out, data_uart_tx_out, 8'(8'h41 + i));
      end
      @(negedge clk);
    end
    ctrl_uart_tx_ready_in = 1'b0;
    checks++;
    if (ctrl_uart_tx_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL tx_drained_valid: got %b want 0", ctrl_uart_tx_valid_out);
    end
    load(A_STAT, v);
    checks++;
    if (v !== 32'hD) begin
      errors++;
      $display("FAIL tx_drop_sticky: got %h want 0000000d", v);
    end
    store(A_STAT, 32'h4);
    load(A_STAT, v);
    checks++;
    if (v !== 32'h9) begin
      errors++;
      $display("FAIL tx_empty_status: got %h want 00000009", v);
    end
  endtask

  task automatic test_rx;
    logic [31:0] v;
    ctrl_uart_rx_valid_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_uart_rx_in = 8'(8'h10 + i);
      checks++;
      if (ctrl_uart_rx_ready_out !== (i < 4)) begin
        errors++;
        $display("FAIL rx_ready%0d: got %b want %b", i,
                 ctrl_uart_rx_ready_out, (i < 4));
      end
      if (i < 4) @(negedge clk);
    end
    load(A_STAT, v);
    checks++;
    if (v !== 32'hB) begin
      errors++;
      $display("FAIL rx_full_status: got %h want 0000000b", v);
    end
    load(A_RX, v);
    checks++;
    if (v !== 32'h10 || ctrl_uart_rx_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL rx_pop_full: data=%h ready=%b want 10 1", v,
               ctrl_uart_rx_ready_out);
    end
    load(A_RX, v);
    ctrl_uart_rx_valid_in = 1'b0;
    checks++;
    if (v !== 32'h11) begin
      errors++;
      $display("FAIL rx_pop_push: got %h want 11", v);
    end
    for (int i = 0; i < 3; i++) begin
      load(A_RX, v);
      checks++;
      if (v !== 32'(8'h12 + i)) begin
        errors++;
        $display("FAIL rx_order%0d: got %h want %h", i, v, 8'(8'h12 + i));
      end
    end
    load(A_RX, v);
    checks++;
    if (v !== 32'h0) begin
      errors++;
      $display("FAIL rx_empty_load: got %h want 0", v);
    end
  endtask

  task automatic test_unmapped;
    logic [31:0] v;
    store(A_RX, 32'h55);
    store(32'h0000_0008, 32'h66);
    load(32'h8000_000C, v);
    checks++;
    if (v !== 32'h0) begin
      errors++;
      $display("FAIL unmapped_load: got %h want 0", v);
    end
    load(A_STAT, v);
    checks++;
    if (v !== 32'h9) begin
      errors++;
      $display("FAIL unmapped_store: status %h want 00000009", v);
    end
  endtask

  task automatic test_counters;
    logic [31:0] v;
    for (int i = 0; i < 100; i++) begin
      inst_valid_in = i[0];
      @(negedge clk);
    end
    inst_valid_in = 1'b1;
    store(A_CRST, 32'h0);
    inst_valid_in = 1'b0;
    load(A_CYC, v);
    checks++;
    if (v !== 32'h0) begin
      errors++;
      $display("FAIL cyc_after_clr: got %h want 0", v);
    end
    load(A_INST, v);
    checks++;
    if (v !== 32'h0) begin
      errors++;
      $display("FAIL inst_after_clr: got %h want 0", v);
    end
    for (int i = 0; i < 10; i++) begin
      inst_valid_in = !i[0];
      @(negedge clk);
    end
    inst_valid_in = 1'b0;
    load(A_CYC, v);
    checks++;
    if (v !== 32'd12) begin
      errors++;
      $display("FAIL cyc_elapsed: got %0d want 12", v);
    end
    load(A_INST, v);
    checks++;
    if (v !== 32'd5) begin
      errors++;
      $display("FAIL inst_elapsed: got %0d want 5", v);
    end
  endtask

  task automatic test_wrap;
    logic [31:0] exp_v [3];
    exp_v[0] = 32'hFFFF_FFFE;
    exp_v[1] = 32'hFFFF_FFFF;
    exp_v[2] = 32'h0;
    force dut.cyc_q = 32'hFFFF_FFFE;
    #1;
    release dut.cyc_q;
    addr_in = A_CYC;
    re_in   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (data_reg_out !== exp_v[i]) begin
        errors++;
        $display("FAIL cyc_wrap%0d: got %h want %h", i, data_reg_out, exp_v[i]);
      end
    end
    re_in   = 1'b0;
    addr_in = '0;
  endtask

  task automatic test_drop_clear;
    logic [31:0] v;
    ctrl_uart_tx_ready_in = 1'b0;
    for (int i = 0; i < 5; i++) store(A_TX, 32'h20 + i);
    store(A_STAT, 32'h3);
    load(A_STAT, v);
    checks++;
    if (v !== 32'h4) begin
      errors++;
      $display("FAIL drop_noclr: got %h want 00000004", v);
    end
    store(A_STAT, 32'h4);
    load(A_STAT, v);
    checks++;
    if (v !== 32'h0) begin
      errors++;
      $display("FAIL drop_clr: got %h want 00000000", v);
    end
    ctrl_uart_tx_ready_in = 1'b1;
    store(A_TX, 32'h99);
    repeat (5) @(negedge clk);
    ctrl_uart_tx_ready_in = 1'b0;
    load(A_STAT, v);
    checks++;
    if (v !== 32'hD) begin
      errors++;
      $display("FAIL drop_pop_same_cycle: got %h want 0000000d", v);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] v;
    store(A_STAT, 32'h4);
    for (int i = 0; i < 5; i++) store(A_TX, 32'h30 + i);
    ctrl_uart_tx_ready_in = 1'b1;
    repeat (2) @(negedge clk);
    ctrl_uart_tx_ready_in = 1'b0;
    ctrl_uart_rx_valid_in = 1'b1;
    data_uart_rx_in = 8'h77;
    @(negedge clk);
    ctrl_uart_rx_valid_in = 1'b0;
    load(A_STAT, v);
    checks++;
    if (v !== 32'h7) begin
      errors++;
      $display("FAIL pre_reset_status: got %h want 00000007", v);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (ctrl_uart_tx_valid_out !== 1'b0 || ctrl_uart_rx_ready_out !== 1'b1
        || data_reg_out !== 32'h0 || data_uart_tx_out !== 8'h0) begin
      errors++;
      $display("FAIL mid_reset_outs: txv=%b rxr=%b dreg=%h dtx=%h want 0 1 0 0",
               ctrl_uart_tx_valid_out, ctrl_uart_rx_ready_out,
               data_reg_out, data_uart_tx_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    load(A_CYC, v);
    checks++;
    if (v !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_cyc: got %h want 0", v);
    end
    load(A_STAT, v);
    checks++;
    if (v !== 32'h9) begin
      errors++;
      $display("FAIL mid_reset_status: got %h want 00000009", v);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    addr_in = '0;
    data_in = '0;
    we_in = 1'b0;
    re_in = 1'b0;
    inst_valid_in = 1'b0;
    ctrl_uart_tx_ready_in = 1'b0;
    data_uart_rx_in = '0;
    ctrl_uart_rx_valid_in = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_tx();
    test_rx();
    test_unmapped();
    test_counters();
    test_wrap();
    test_drop_clear();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
